// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the HI/LO
// multiply/divide sequencer.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  stall, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output stall, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide sequencer: radix-2 shift-add multiply,
// restoring divide, sign fix-up, one iteration per cycle.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               dz_q;

    logic               md_req;
    logic               sgn_op;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic               qbit;
    logic [WIDTH-1:0]   newrem;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign md_req = bus.start && (state == IDLE) && !bus.op[2];
    assign bus.stall = (state != IDLE) || md_req;
    assign bus.done = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi = hi_q;
    assign bus.lo = lo_q;

    assign sgn_op = !bus.op[0];
    assign mag_a = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, opnd} : '0);

    // Divide: acc = {remainder, dividend bits / quotient bits}
    assign shifted = acc[2*WIDTH-1:WIDTH-1];
    assign diff = {1'b0, shifted} - {2'b0, opnd};
    assign qbit = !diff[WIDTH+1];
    assign newrem = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

    assign prod_neg = -acc;
    assign quo = acc[WIDTH-1:0];
    assign rem = acc[2*WIDTH-1:WIDTH];

    always_comb begin
        fix_hi = acc[2*WIDTH-1:WIDTH];
        fix_lo = acc[WIDTH-1:0];
        if (is_div) begin
            fix_lo = neg_q ? -quo : quo;
            fix_hi = neg_r ? -rem : rem;
        end else if (neg_q) begin
            fix_hi = prod_neg[2*WIDTH-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            3'b100: hi_q <= bus.a;
                            3'b101: lo_q <= bus.a;
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                if (bus.op[1] && bus.b == '0) begin
                                    done_q <= 1'b1;
                                    dz_q   <= 1'b1;
                                end else begin
                                    is_div <= bus.op[1];
                                    neg_q  <= sgn_op &&
                                              (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                    neg_r  <= sgn_op && bus.a[WIDTH-1];
                                    acc    <= bus.op[1] ? {{WIDTH{1'b0}}, mag_a}
                                                        : {{WIDTH{1'b0}}, mag_b};
                                    opnd   <= bus.op[1] ? mag_b : mag_a;
                                    cnt    <= '0;
                                    state  <= CALC;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc <= is_div ? {newrem, acc[WIDTH-2:0], qbit}
                                  : {msum, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed bench for muldiv_ctrl against an
// arithmetic HI/LO reference model.
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int passed = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    muldiv_if bus();

    muldiv_ctrl dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic bit predict(input logic [2:0] op,
                                   input logic [31:0] a, b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q;
        longint r;
        logic [63:0] p;
        bit dz = 1'b0;
        case (op)
            3'd0: begin
                p = sa * sb;
                mhi = p[63:32];
                mlo = p[31:0];
            end
            3'd1: begin
                p = {32'b0, a} * {32'b0, b};
                mhi = p[63:32];
                mlo = p[31:0];
            end
            3'd2: begin
                if (b == 0) dz = 1'b1;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = q;
                    mlo = p[31:0];
                    p = r;
                    mhi = p[31:0];
                end
            end
            3'd3: begin
                if (b == 0) dz = 1'b1;
                else begin
                    mlo = a / b;
                    mhi = a % b;
                end
            end
            3'd4: mhi = a;
            3'd5: mlo = a;
            default: ;
        endcase
        return dz;
    endfunction

    // lat = cycles after start edge until done (0 = timed out)
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, b,
                          input bit now, input int inj,
                          output int lat, output int stl,
                          output bit dz, output bit req_stall);
        if (!now) @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        #1 req_stall = bus.stall;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        stl = 0;
        dz = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (n == inj) begin
                bus.start = 1'b1;
                bus.op = 3'b101;
                bus.a = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                lat = n;
                dz = bus.div_zero;
                break;
            end
            if (bus.stall) stl++;
        end
        bus.start = 1'b0;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a,
                      output bit st);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        #1 st = bus.stall;
        @(posedge clk);
        #1 bus.start = 1'b0;
        void'(predict(op, a, 32'h0));
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (bus.hi !== 0 || bus.lo !== 0 || bus.done !== 0 ||
            bus.stall !== 0)
            $display("FAIL reset_state hi=%h lo=%h done=%b stall=%b want 0",
                     bus.hi, bus.lo, bus.done, bus.stall);
        else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.hi !== 0 || bus.lo !== 0 || bus.done !== 0)
            $display("FAIL reset_release hi=%h lo=%h done=%b want 0",
                     bus.hi, bus.lo, bus.done);
        else passed++;
    endtask

    task automatic test_mt;
        bit st;
        mt(3'b100, 32'h1234_5678, st);
        checks++;
        if (st !== 1'b0 || bus.hi !== 32'h1234_5678)
            $display("FAIL mthi stall=%b hi=%h want 0 12345678", st, bus.hi);
        else passed++;
        mt(3'b101, 32'hCAFE_0001, st);
        checks++;
        if (st !== 1'b0 || bus.lo !== mlo || bus.hi !== mhi)
            $display("FAIL mtlo stall=%b hi=%h lo=%h want 0 %h %h",
                     st, bus.hi, bus.lo, mhi, mlo);
        else passed++;
    endtask

    task automatic test_noop;
        bit st;
        mt(3'b110, 32'h5555_5555, st);
        #1;
        checks++;
        if (st !== 1'b0 || bus.done !== 1'b0 ||
            bus.hi !== mhi || bus.lo !== mlo)
            $display("FAIL noop stall=%b done=%b hi=%h lo=%h want 0 0 %h %h",
                     st, bus.done, bus.hi, bus.lo, mhi, mlo);
        else passed++;
    endtask

    task automatic test_directed;
        logic [2:0]  ops [5] = '{3'd1, 3'd0, 3'd2, 3'd2, 3'd3};
        logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9,
                                 32'h8000_0000, 32'd100};
        logic [31:0] bs  [5] = '{32'hFFFF_FFFF, 32'd5, 32'd2,
                                 32'hFFFF_FFFF, 32'd7};
        logic [31:0] eh  [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h0, 32'd2};
        logic [31:0] el  [5] = '{32'h1, 32'hFFFF_FFF1, 32'hFFFF_FFFD,
                                 32'h8000_0000, 32'd14};
        int lat, stl;
        bit dz, rs;
        for (int i = 0; i < 5; i++) begin
            void'(predict(ops[i], as[i], bs[i]));
            run_md(ops[i], as[i], bs[i], 1'b0, 0, lat, stl, dz, rs);
            checks++;
            if (lat != 34 || stl != 33 || rs !== 1'b1 || dz !== 1'b0)
                $display("FAIL dir%0d_timing lat=%0d stl=%0d rs=%b dz=%b want 34 33 1 0",
                         i, lat, stl, rs, dz);
            else passed++;
            checks++;
            if (bus.hi !== eh[i] || bus.lo !== el[i])
                $display("FAIL dir%0d_result hi=%h lo=%h want %h %h",
                         i, bus.hi, bus.lo, eh[i], el[i]);
            else passed++;
        end
    endtask

    task automatic test_div_zero;
        bit st, dz, rs;
        int lat, stl;
        mt(3'b100, 32'h11, st);
        mt(3'b101, 32'h22, st);
        run_md(3'b011, 32'd7, 32'd0, 1'b0, 0, lat, stl, dz, rs);
        checks++;
        if (lat != 1 || dz !== 1'b1 || rs !== 1'b1 || bus.stall !== 1'b0)
            $display("FAIL divzero_pulse lat=%0d dz=%b rs=%b stall=%b want 1 1 1 0",
                     lat, dz, rs, bus.stall);
        else passed++;
        checks++;
        if (bus.hi !== 32'h11 || bus.lo !== 32'h22)
            $display("FAIL divzero_hilo hi=%h lo=%h want 11 22", bus.hi, bus.lo);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.div_zero !== 1'b0)
            $display("FAIL divzero_oneshot done=%b dz=%b want 0 0",
                     bus.done, bus.div_zero);
        else passed++;
    endtask

    task automatic test_ignore;
        int lat, stl;
        bit dz, rs;
        void'(predict(3'd1, 32'd1000, 32'd3000));
        run_md(3'd1, 32'd1000, 32'd3000, 1'b0, 5, lat, stl, dz, rs);
        checks++;
        if (lat != 34 || bus.hi !== mhi || bus.lo !== mlo)
            $display("FAIL mtlo_in_calc lat=%0d hi=%h lo=%h want 34 %h %h",
                     lat, bus.hi, bus.lo, mhi, mlo);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int lat, stl;
        bit dz, rs;
        void'(predict(3'd3, 32'd1000, 32'd7));
        run_md(3'd3, 32'd1000, 32'd7, 1'b0, 0, lat, stl, dz, rs);
        void'(predict(3'd0, 32'hFFFF_FF00, 32'd77));
        run_md(3'd0, 32'hFFFF_FF00, 32'd77, 1'b1, 0, lat, stl, dz, rs);
        checks++;
        if (rs !== 1'b1 || lat != 34 || bus.hi !== mhi || bus.lo !== mlo)
            $display("FAIL back_to_back rs=%b lat=%0d hi=%h lo=%h want 1 34 %h %h",
                     rs, lat, bus.hi, bus.lo, mhi, mlo);
        else passed++;
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b;
        int lat, stl, sel;
        bit dz, rs, edz;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 3));
            a = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom;
            endcase
            edz = predict(op, a, b);
            run_md(op, a, b, 1'b0, 0, lat, stl, dz, rs);
            checks++;
            if (lat != (edz ? 1 : 34) || dz !== edz || rs !== 1'b1)
                $display("FAIL rnd%0d_timing op=%0d lat=%0d dz=%b rs=%b want %0d %b 1",
                         i, op, lat, dz, rs, edz ? 1 : 34, edz);
            else passed++;
            checks++;
            if (bus.hi !== mhi || bus.lo !== mlo)
                $display("FAIL rnd%0d_result op=%0d a=%h b=%h hi=%h lo=%h want %h %h",
                         i, op, a, b, bus.hi, bus.lo, mhi, mlo);
            else passed++;
        end
    endtask

    task automatic test_reset_mid;
        int lat, stl, seen;
        bit dz, rs;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 3'd1;
        bus.a = 32'hFFFF_0000;
        bus.b = 32'h0001_FFFF;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.hi !== 0 || bus.lo !== 0 || bus.stall !== 1'b0)
            $display("FAIL reset_mid hi=%h lo=%h stall=%b want 0 0 0",
                     bus.hi, bus.lo, bus.stall);
        else passed++;
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        checks++;
        if (seen != 0 || bus.hi !== 0 || bus.lo !== 0)
            $display("FAIL reset_mid_nodone done_cnt=%0d hi=%h lo=%h want 0 0 0",
                     seen, bus.hi, bus.lo);
        else passed++;
        void'(predict(3'd1, 32'd6, 32'd7));
        run_md(3'd1, 32'd6, 32'd7, 1'b0, 0, lat, stl, dz, rs);
        checks++;
        if (lat != 34 || bus.lo !== 32'd42 || bus.hi !== 32'd0)
            $display("FAIL reset_mid_after lat=%0d hi=%h lo=%h want 34 0 2a",
                     lat, bus.hi, bus.lo);
        else passed++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.a = '0;
        bus.b = '0;
        test_reset();
        test_mt();
        test_noop();
        test_directed();
        test_div_zero();
        test_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencing controller for the CPU's HI/LO arithmetic.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the decode/execute stage.
- Runs a radix-2 iterative shift-add multiply or restoring divide over 32 cycles, applies sign correction, and writes the HI/LO architectural registers.
- Asserts a stall to the core while busy; replaces the combinational 32-partial-product array multiplier in the execute path.

Parameters:
WIDTH  32  operand width; HI/LO each WIDTH bits; iteration count = WIDTH

Ports:
clk       in   1      rising-edge clock
reset     in   1      asynchronous, active-high reset
start     in   1      request valid this cycle
op        in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
a         in   WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
b         in   WIDTH  rt operand (divisor / multiplier)
stall     out  1      core must hold PC/pipeline this cycle
done      out  1      one-cycle pulse: HI/LO updated by mult/div this edge
div_zero  out  1      one-cycle pulse with done when divisor was 0
hi        out  WIDTH  HI register
lo        out  WIDTH  LO register

Behaviour:
- Reset (async, active-high): state=IDLE; hi=lo=0; done=div_zero=0; internal accumulators cleared. Reset mid-operation aborts the operation and leaves no partial HI/LO write.
- States: IDLE, CALC, FIX.
- IDLE + start + op MTHI/MTLO: write a into hi or lo at this edge. No stall, stays IDLE.
- IDLE + start + op mult/div, b!=0 or mult:
  - latch |a|, |b| (signed ops) or a, b (unsigned ops), plus sign flags;
  - counter=0; go to CALC.
- IDLE + start + DIV/DIVU with b==0: stay IDLE. hi/lo unchanged. done=div_zero=1 next cycle (registered pulse). stall high for the request cycle only.
- CALC: one iteration per cycle, counter 0..WIDTH-1. At counter==WIDTH-1 go to FIX.
  - Multiply: 2*WIDTH-bit product register, add multiplicand when multiplier LSB=1, shift right.
  - Divide: restoring, WIDTH+1-bit trial subtract per cycle; quotient bit shifted in.
- FIX:
  - Signed MULT: negate the 64-bit product (two's complement) if sign(a)^sign(b).
  - Signed DIV: quotient negated if sign(a)^sign(b); remainder takes sign(a).
  - Unsigned ops pass through.
  - Writes hi=product[63:32] or remainder, lo=product[31:0] or quotient at the FIX exit edge. done=1 the following cycle; state=IDLE.
- Latency: start edge -> 32 CALC cycles -> 1 FIX cycle. HI/LO are visible 34 cycles after the start edge; done is high in cycle 34.
- stall is combinational: (state!=IDLE) | (state==IDLE & start & op in {000..011}). The core re-presents the same instruction while stalled.
- start while state!=IDLE: ignored, including MTHI/MTLO. stall already holds the core.
- Back-to-back: a new start is accepted in the cycle done is high; the new operation uses the just-written hi/lo.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Width rules: all internal arithmetic is unsigned on magnitudes. Negation of 0x80000000 magnitude is handled in WIDTH+1 bits.
- op 11x with start: no effect, no stall.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> stall 33 cycles from start; done at cycle 34; hi=0xFFFFFFFE lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- DIVU a=7 b=0 with hi=0x11, lo=0x22 -> next cycle done=div_zero=1, hi/lo unchanged, stall only in request cycle.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0x00000000; DIVU a=100 b=7 -> lo=14 hi=2.
- MTHI a=0x12345678 in IDLE -> hi=0x12345678 next edge, stall=0; MTLO during CALC -> ignored, lo keeps final result.
- reset asserted asynchronously at CALC cycle 10 -> hi=lo=0 immediately, stall=0, done never pulses; next MULTU 6*7 gives lo=42, hi=0.
